// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_DESELECT = 2'd0,
        IDLE          = 2'd1,
        LOAD          = 2'd2,
        SHIFT         = 2'd3
    } spi_slave_state_t;

    localparam logic        SPI_IDLE_LEVEL  = 1'b1;
    localparam int unsigned SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_if.sv
// Host-side handshake plus SPI pins of the responder, bundled as one interface.
interface spi_slave_if #(
    parameter int unsigned DATASIZE = 8
);
    logic [DATASIZE-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [DATASIZE-1:0] rx_data;
    logic                rx_valid;
    logic                tx_underrun;
    logic                selected;
    logic                spi_clk;
    logic                spi_csn;
    logic                spi_sdi;
    logic                spi_sdo;

    modport slave (
        input  tx_data, tx_valid, spi_clk, spi_csn, spi_sdi,
        output tx_ready, rx_data, rx_valid, tx_underrun, selected, spi_sdo
    );

    modport master (
        output tx_data, tx_valid, spi_clk, spi_csn, spi_sdi,
        input  tx_ready, rx_data, rx_valid, tx_underrun, selected, spi_sdo
    );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with optional edge decode.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned STAGES      = SPI_SYNC_STAGES,
    parameter logic        RESET_VAL   = SPI_IDLE_LEVEL,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

    // Edges come from comparing the synced value with one more delayed copy.
    if (EDGE_DETECT) begin : g_edge
        logic last_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                last_q <= RESET_VAL;
            end else begin
                last_q <= q;
            end
        end

        assign rise_c = q & ~last_q;
        assign fall_c = ~q & last_q;
    end else begin : g_no_edge
        assign rise_c = 1'b0;
        assign fall_c = 1'b0;
    end

endmodule

// File: rtl/spi_slave.sv
// SPI responder (clock idles high, sample on rising, MSB first) running entirely in the clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned         DATASIZE      = 8,
    parameter logic [DATASIZE-1:0] FILL_WORD     = '1,
    parameter int unsigned         CLK_FREQUENCY = 50_000_000,
    parameter int unsigned         SPI_FREQUENCY = 2_000_000
) (
    input logic        clk,
    input logic        reset,
    spi_slave_if.slave bus
);

    localparam int unsigned CNT_W    = $clog2(DATASIZE);
    localparam int unsigned SETTLE_W = $clog2(SPI_SYNC_STAGES + 1);

    if (DATASIZE < 2) begin : g_bad_size
        $error("spi_slave: DATASIZE must be at least 2");
    end
    if (64'(CLK_FREQUENCY) < 64'(SPI_FREQUENCY) * 64'd10) begin : g_bad_ratio
        $error("spi_slave: CLK_FREQUENCY must be at least 10x SPI_FREQUENCY");
    end

    logic sclk_unused, sclk_rise_c, sclk_fall_c;
    logic csn_q, csn_rise_c, csn_fall_c;
    logic sdi_q, sdi_rise_unused, sdi_fall_unused;

    spi_sync #(.EDGE_DETECT(1'b1)) u_sync_clk (
        .clk(clk), .reset(reset), .d(bus.spi_clk),
        .q(sclk_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_sync #(.EDGE_DETECT(1'b1)) u_sync_csn (
        .clk(clk), .reset(reset), .d(bus.spi_csn),
        .q(csn_q), .rise_c(csn_rise_c), .fall_c(csn_fall_c)
    );

    spi_sync #(.EDGE_DETECT(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .d(bus.spi_sdi),
        .q(sdi_q), .rise_c(sdi_rise_unused), .fall_c(sdi_fall_unused)
    );

    spi_slave_state_t      state_q;
    logic [SETTLE_W-1:0]   settle_q;
    logic [DATASIZE-1:0]   hold_q;
    logic                  tx_ready_q;
    logic [DATASIZE-1:0]   tx_shift_q;
    logic [DATASIZE-2:0]   rx_shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATASIZE-1:0]   rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_underrun_q;
    logic                  selected_q;
    logic                  sdo_q;

    logic                  settled_c;
    logic [DATASIZE-1:0]   load_word_c;
    logic [DATASIZE-1:0]   rx_next_c;

    // The sync flops reset to idle, so trust the synced chip select only after they refill.
    assign settled_c   = (settle_q == SETTLE_W'(SPI_SYNC_STAGES));
    assign load_word_c = tx_ready_q ? FILL_WORD : hold_q;
    assign rx_next_c   = {rx_shift_q, sdi_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_DESELECT;
            settle_q      <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            tx_shift_q    <= '1;
            rx_shift_q    <= '0;
            cnt_q         <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            selected_q    <= 1'b0;
            sdo_q         <= SPI_IDLE_LEVEL;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;

            if (!settled_c) begin
                settle_q <= settle_q + SETTLE_W'(1);
            end

            if (bus.tx_valid && tx_ready_q) begin
                hold_q     <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end

            // Deselect wins over everything, including a word completing in the same cycle.
            if (csn_rise_c) begin
                state_q    <= IDLE;
                selected_q <= 1'b0;
                sdo_q      <= SPI_IDLE_LEVEL;
            end else begin
                case (state_q)
                    WAIT_DESELECT: begin
                        if (settled_c && csn_q) begin
                            state_q <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (csn_fall_c) begin
                            state_q    <= LOAD;
                            selected_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (tx_ready_q) begin
                            tx_underrun_q <= 1'b1;
                        end else begin
                            tx_ready_q <= !bus.tx_valid;
                            if (bus.tx_valid) begin
                                hold_q <= bus.tx_data;
                            end
                        end
                        // A falling edge right behind chip select must already shift the new MSB.
                        if (sclk_fall_c) begin
                            sdo_q      <= load_word_c[DATASIZE-1];
                            tx_shift_q <= {load_word_c[DATASIZE-2:0], 1'b0};
                        end else begin
                            tx_shift_q <= load_word_c;
                        end
                        cnt_q   <= CNT_W'(DATASIZE - 1);
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_fall_c) begin
                            sdo_q      <= tx_shift_q[DATASIZE-1];
                            tx_shift_q <= {tx_shift_q[DATASIZE-2:0], 1'b0};
                        end
                        if (sclk_rise_c) begin
                            rx_shift_q <= rx_next_c[DATASIZE-2:0];
                            if (cnt_q != '0) begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end else begin
                                rx_data_q  <= rx_next_c;
                                rx_valid_q <= 1'b1;
                                state_q    <= LOAD;
                            end
                        end
                    end
                    default: begin
                        state_q <= WAIT_DESELECT;
                    end
                endcase
            end
        end
    end

    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.selected    = selected_q;
    assign bus.spi_sdo     = sdo_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI peripheral (responder) that sits on the far end of the team's SPI master link: SPI clock idles high, data is driven on falling edges and sampled on rising edges, MSB first, active-low chip select. All SPI pins are sampled in the single `clk` domain through synchronizers, so no logic runs on `spi_clk`. Received words are delivered on a one-cycle `rx_valid` strobe. Reply words come from a one-entry host holding register. A chip-select burst may carry any number of back-to-back words.

## Interface
- `DATASIZE`, 8: bits per word; must be ≥ 2.
- `FILL_WORD`, all ones: word shifted out when no host word is pending at a word start.
- `CLK_FREQUENCY`, 50_000_000: `clk` frequency in Hz.
- `SPI_FREQUENCY`, 2_000_000: maximum SPI clock frequency in Hz. Elaboration fails unless `CLK_FREQUENCY` ≥ 10 × `SPI_FREQUENCY`.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in `DATASIZE`: reply word from the host.
- `tx_valid` in 1: `tx_data` is offered. Captured when `tx_valid && tx_ready`.
- `tx_ready` out 1: holding register is empty.
- `rx_data` out `DATASIZE`: last complete received word. Held until the next word completes.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new.
- `tx_underrun` out 1: one-cycle strobe; `FILL_WORD` was loaded because the holding register was empty.
- `selected` out 1: high in LOAD and SHIFT states.
- `spi_clk` in 1: from master, asynchronous.
- `spi_csn` in 1: from master, asynchronous, active low.
- `spi_sdi` in 1: master-to-slave data, asynchronous.
- `spi_sdo` out 1: slave-to-master data.

## Operation
- **Synchronizers**
  - Each SPI input passes through 2 flops.
  - `spi_clk` and `spi_csn` also have a third "last" flop. Edges are decoded from the synced and last values.
  - All sync flops reset to 1.
- **WAIT_DESELECT** (reset state): `spi_sdo` = 1. Go to IDLE when synced `spi_csn` = 1. This prevents joining a transfer mid-word.
- **IDLE**: `spi_sdo` = 1. A detected `spi_csn` falling edge moves to LOAD.
- **LOAD** (1 cycle):
  - Shift register ← holding register if full, which then empties; otherwise ← `FILL_WORD` and `tx_underrun` pulses.
  - Bit counter ← `DATASIZE`-1. Go to SHIFT.
- **SHIFT**
  - Detected `spi_clk` falling edge: `spi_sdo` ← shift[MSB], then the tx shift register shifts left by 1.
  - Detected `spi_clk` rising edge: rx shift ← {rx shift[`DATASIZE`-2:0], synced `spi_sdi`}.
  - On a rising edge with counter ≠ 0: decrement the counter.
  - On a rising edge with counter = 0, next cycle:
    - `rx_data` ← completed word and `rx_valid` = 1.
    - Go to LOAD, so the next word is ready before the next falling edge.
- **Any state**: a detected `spi_csn` rising edge goes to IDLE and sets `spi_sdo` ← 1.
  - A partial word is discarded: no `rx_valid`, and the tx word is lost.
  - The holding register is untouched.
- **Host side**
  - `tx_ready` = holding register empty.
  - The holding register reloads in the same cycle LOAD empties it only if `tx_valid`; that capture counts as the new content.
  - No rx backpressure: `rx_data` is overwritten by the next completed word.
- **Counter width**: $clog2(`DATASIZE`), with no wrap beyond 0.

## Timing
- **Reset values**:
  - `spi_sdo` = 1, `rx_valid` = 0, `tx_underrun` = 0, `selected` = 0, `tx_ready` = 1, `rx_data` = 0.
  - State = WAIT_DESELECT.
- **Edge-detect latency**: a pin edge is decoded on the 3rd `clk` edge after it. `spi_sdo` updates ≤ 4 `clk` cycles after an `spi_clk` falling pin edge.
- **`rx_valid` latency**: asserted 4 cycles after the last rising pin edge of a word.
- **Chip select to first falling edge**: the master may drop `spi_clk` 1 `clk` cycle after `spi_csn`. The synced copies keep that spacing, LOAD completes in that cycle, and the first falling edge shifts the new MSB.
- **Simultaneous events**: a `spi_csn` rising edge in the same cycle as the final rising edge means deselect wins and the word is discarded. The master holds `spi_csn` low ≥ 1 cycle after its last rising edge, so normal transfers complete.

## Structure
- `spi_pkg`:
  - `spi_slave_state_t` enum {WAIT_DESELECT, IDLE, LOAD, SHIFT}, 2 bits.
  - Constants `SPI_IDLE_LEVEL` = 1 (clock and data idle level) and `SPI_SYNC_STAGES` = 2.
- Sub-module `spi_sync`:
  - Parameterized synchronizer with optional rise/fall decode.
  - Instanced for `spi_clk`, `spi_csn` and `spi_sdi`.

## Test plan
- **Single word**: master sends 8'hA5 with host `tx_data` = 8'h3C preloaded → `rx_data` = 8'hA5 with one `rx_valid` pulse; master reads 8'h3C; `tx_ready` returns to 1 in LOAD.
- **Two-word burst**: master sends 8'h12, 8'h34 under one chip select; host supplies 8'hF0 and 8'h0F → two `rx_valid` pulses in order; master reads 8'hF0, 8'h0F; no `tx_underrun`.
- **Underrun**: no host word pending → master reads 8'hFF; `tx_underrun` pulses once, in LOAD.
- **Abort**: `spi_csn` raised after 3 bits → no `rx_valid`; `spi_sdo` = 1 within 4 cycles; next full transfer of 8'h5A is received correctly.
- **Reset mid-transfer**: `reset` pulsed while `spi_csn` = 0 and bits are toggling → stays in WAIT_DESELECT with no `rx_valid` until `spi_csn` = 1; next transfer is correct.
- **Clock ratio**: `SPI_FREQUENCY` at the `CLK_FREQUENCY`/10 limit with a random 100-word burst → every word is bit-exact in both directions.
